alarm_controller: RTL and testbench

Sequencing core of the alarm clock jukebox. Compares the running time from the timekeeper against the user-set alarm time and walks an arm/ring/snooze state machine. Drives the speaker square wave, the alarm LED and the 2-bit status LEDs. Sits between the timekeeper and debounce logic (inputs) and the speaker/LED PIO exports (outputs).

---
 rtl/alarm_pkg.sv | 16 +
 rtl/alarm_tone_gen.sv | 34 +++
 rtl/alarm_controller.sv | 119 +++++++++++
 tb/tb_alarm_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and field widths for the alarm clock sequencing core.
package alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  // Encoding doubles as the led_status code.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_RINGING = 2'b10,
    ST_SNOOZE  = 2'b11
  } alarm_state_e;

endpackage

// File: rtl/alarm_tone_gen.sv
// Square-wave tone source: toggles every TONE_HALF enabled cycles, parked low when disabled.
module tone_gen #(
  parameter int TONE_HALF = 56818
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic out
);

  localparam int CW = $clog2(TONE_HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(TONE_HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (!en) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      r_out <= ~r_out;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out = r_out;

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencing core: time match, arm/ring/snooze FSM, ring and snooze second counters.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TONE_HALF      = 56818,
  parameter int SNOOZE_S       = 300,
  parameter int RING_TIMEOUT_S = 600
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              sec_tick,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic              alarm_en,
  input  logic              snooze_btn,
  input  logic              stop_btn,
  output logic              speaker,
  output logic              led_alarm,
  output logic [1:0]        led_status
);

  localparam int RW = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
  localparam int SW = $clog2(SNOOZE_S + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_S - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_S);
  localparam logic [SW-1:0] SNZ_ONE   = SW'(1);

  if (CLK_HZ < 1 || TONE_HALF < 1 || SNOOZE_S < 1 || RING_TIMEOUT_S < 1) begin : g_param_chk
    $error("alarm_controller: parameters must all be >= 1");
  end

  alarm_state_e  r_state, w_state_nxt;
  logic [RW-1:0] r_ring_cnt, w_ring_nxt;
  logic [SW-1:0] r_snz_cnt, w_snz_nxt;
  logic          r_led_alarm;
  logic          w_match;
  logic          w_tone_en;

  assign w_match = sec_tick && (cur_hour == alarm_hour) && (cur_min == alarm_min) &&
                   (cur_sec == '0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= ST_IDLE;
      r_ring_cnt  <= '0;
      r_snz_cnt   <= '0;
      r_led_alarm <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ring_cnt  <= w_ring_nxt;
      r_snz_cnt   <= w_snz_nxt;
      r_led_alarm <= (w_state_nxt == ST_RINGING);
    end
  end

  // Buttons are tested before sec_tick, so a coincident tick leaves the counters alone.
  always_comb begin
    w_state_nxt = r_state;
    w_ring_nxt  = r_ring_cnt;
    w_snz_nxt   = r_snz_cnt;
    if (!alarm_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: w_state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (w_match) begin
            w_state_nxt = ST_RINGING;
            w_ring_nxt  = '0;
          end
        end
        ST_RINGING: begin
          if (stop_btn) begin
            w_state_nxt = ST_ARMED;
          end else if (snooze_btn) begin
            w_state_nxt = ST_SNOOZE;
            w_snz_nxt   = SNZ_LOAD;
          end else if (sec_tick) begin
            if (r_ring_cnt == RING_LAST) w_state_nxt = ST_ARMED;
            else                         w_ring_nxt  = r_ring_cnt + 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (stop_btn) begin
            w_state_nxt = ST_ARMED;
          end else if (sec_tick) begin
            if (r_snz_cnt == SNZ_ONE) begin
              w_state_nxt = ST_RINGING;
              w_ring_nxt  = '0;
            end else begin
              w_snz_nxt = r_snz_cnt - 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Even ring seconds sound, odd ones are silent.
  assign w_tone_en = (r_state == ST_RINGING) && !r_ring_cnt[0];

  tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clk    (clk_clk),
    .reset_n(reset_reset_n),
    .en     (w_tone_en),
    .out    (speaker)
  );

  assign led_alarm  = r_led_alarm;
  assign led_status = r_state;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios then random traffic against a behavioural model.
module tb_alarm_controller;

  localparam int TH = 4;
  localparam int SN = 3;
  localparam int RT = 4;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic       sec_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic       snooze_btn;
  logic       stop_btn;
  logic       speaker;
  logic       led_alarm;
  logic [1:0] led_status;

  alarm_controller #(
    .CLK_HZ        (50_000_000),
    .TONE_HALF     (TH),
    .SNOOZE_S      (SN),
    .RING_TIMEOUT_S(RT)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .sec_tick     (sec_tick),
    .cur_hour     (cur_hour),
    .cur_min      (cur_min),
    .cur_sec      (cur_sec),
    .alarm_hour   (alarm_hour),
    .alarm_min    (alarm_min),
    .alarm_en     (alarm_en),
    .snooze_btn   (snooze_btn),
    .stop_btn     (stop_btn),
    .speaker      (speaker),
    .led_alarm    (led_alarm),
    .led_status   (led_status)
  );

  always #5 clk_clk = ~clk_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing.
  int m_mode;
  int m_rung;      // seconds rung since ringing began
  int m_left;      // snooze seconds still to wait
  int m_tone_run;  // consecutive cycles the tone has been enabled
  int m_spk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rung = 0; m_left = 0; m_tone_run = 0; m_spk = 0;
  endtask

  task automatic model_step();
    bit match;
    if (m_mode == 2 && (m_rung % 2) == 0) begin
      m_tone_run++;
      m_spk = (m_tone_run / TH) % 2;
    end else begin
      m_tone_run = 0;
      m_spk = 0;
    end
    match = sec_tick && cur_hour == alarm_hour && cur_min == alarm_min && cur_sec == 0;
    if (!alarm_en) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (match) begin m_mode = 2; m_rung = 0; end
    end else if (m_mode == 2) begin
      if (stop_btn) m_mode = 1;
      else if (snooze_btn) begin m_mode = 3; m_left = SN; end
      else if (sec_tick) begin
        m_rung++;
        if (m_rung == RT) m_mode = 1;
      end
    end else begin
      if (stop_btn) m_mode = 1;
      else if (sec_tick) begin
        m_left--;
        if (m_left == 0) begin m_mode = 2; m_rung = 0; end
      end
    end
  endtask

  task automatic check_outputs();
    check_val("led_status", 32'(led_status), 32'(m_mode));
    check_val("led_alarm", 32'(led_alarm), 32'(m_mode == 2));
    check_val("speaker", 32'(speaker), 32'(m_spk));
  endtask

  task automatic step();
    @(posedge clk_clk);
    model_step();
    #1;
    check_outputs();
    sec_tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick(input int h, input int m, input int s);
    cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    sec_tick = 1'b1;
    step();
  endtask

  initial begin
    reset_reset_n = 1'b0;
    sec_tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0; alarm_en = 1'b0;
    cur_hour = '0; cur_min = '0; cur_sec = '0;
    alarm_hour = 5'd7; alarm_min = 6'd30;
    model_reset();
    #1;
    check_val("rst_status", 32'(led_status), 32'd0);
    check_val("rst_speaker", 32'(speaker), 32'd0);
    check_val("rst_alarm", 32'(led_alarm), 32'd0);
    repeat (2) @(posedge clk_clk);
    #2 reset_reset_n = 1'b1;

    // Idle-state match must not ring.
    idle(2);
    tick(7, 30, 0);
    check_val("idle_nomatch", 32'(led_status), 32'd0);

    alarm_en = 1'b1;
    step();
    check_val("armed", 32'(led_status), 32'd1);
    tick(7, 30, 1);
    tick(7, 29, 0);
    check_val("near_miss", 32'(led_status), 32'd1);
    stop_btn = 1'b1; snooze_btn = 1'b1;
    step();
    tick(7, 30, 0);
    check_val("ring_status", 32'(led_status), 32'd2);
    check_val("ring_led", 32'(led_alarm), 32'd1);
    idle(3);
    check_val("spk_pre_rise", 32'(speaker), 32'd0);
    step();
    check_val("spk_rise", 32'(speaker), 32'd1);
    idle(5);

    // Four unanswered seconds time the ring out.
    for (int t = 0; t < RT; t++) begin
      tick(7, 30, t + 1);
      idle(9);
    end
    check_val("timeout", 32'(led_status), 32'd1);

    // Snooze, extra snooze ignored, re-ring after SN ticks.
    tick(7, 30, 0);
    idle(2);
    snooze_btn = 1'b1;
    step();
    check_val("snooze", 32'(led_status), 32'd3);
    tick(7, 30, 1);
    snooze_btn = 1'b1;
    step();
    tick(7, 30, 2);
    check_val("snooze_hold", 32'(led_status), 32'd3);
    tick(7, 30, 3);
    check_val("re_ring", 32'(led_status), 32'd2);
    idle(6);

    // Snooze pressed on a tick: tick ignored, full snooze follows.
    tick(7, 30, 4);
    snooze_btn = 1'b1; sec_tick = 1'b1;
    step();
    check_val("snz_on_tick", 32'(led_status), 32'd3);
    tick(7, 30, 5);
    tick(7, 30, 6);
    check_val("snz_full", 32'(led_status), 32'd3);
    tick(7, 30, 7);
    idle(3);

    // Stop and snooze together on a tick.
    stop_btn = 1'b1; snooze_btn = 1'b1; sec_tick = 1'b1;
    step();
    check_val("stop_wins", 32'(led_status), 32'd1);

    // alarm_en drop beats stop.
    tick(7, 30, 0);
    alarm_en = 1'b0; stop_btn = 1'b1;
    step();
    check_val("en_drop", 32'(led_status), 32'd0);
    alarm_en = 1'b1;
    step();

    // Asynchronous reset while the speaker is high.
    tick(7, 30, 0);
    idle(5);
    check_val("spk_high", 32'(speaker), 32'd1);
    #2 reset_reset_n = 1'b0;
    model_reset();
    #1;
    check_val("arst_speaker", 32'(speaker), 32'd0);
    check_val("arst_status", 32'(led_status), 32'd0);
    check_val("arst_alarm", 32'(led_alarm), 32'd0);
    alarm_en = 1'b0;
    repeat (2) @(posedge clk_clk);
    #2 reset_reset_n = 1'b1;
    idle(3);
    check_val("post_rst_idle", 32'(led_status), 32'd0);
    alarm_en = 1'b1;
    step();
    check_val("post_rst_arm", 32'(led_status), 32'd1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        sec_tick = 1'b1;
        case ($urandom_range(0, 3))
          0: begin cur_hour = 5'd7; cur_min = 6'd30; cur_sec = 6'd0; end
          1: begin cur_hour = 5'd7; cur_min = 6'd30; cur_sec = 6'($urandom_range(0, 59)); end
          default: begin
            cur_hour = 5'($urandom_range(0, 23));
            cur_min  = 6'($urandom_range(0, 59));
            cur_sec  = 6'($urandom_range(0, 59));
          end
        endcase
      end
      snooze_btn = ($urandom_range(0, 15) == 0);
      stop_btn   = ($urandom_range(0, 23) == 0);
      if (alarm_en) alarm_en = ($urandom_range(0, 63) != 0);
      else          alarm_en = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
